// File: rtl/fetch_sequencer.sv
// Front-end fetch controller: reads an opcode byte plus 0-2 trailing bytes
// from a byte-wide memory port and presents one assembled instruction per
// out_valid/out_ready transfer. Owns the PC and absorbs redirects from execute,
// draining any memory request that is still outstanding.
//
// Handshakes:
//   mem_req/mem_ack : mem_req is held with a stable mem_addr until the cycle
//                     mem_ack is high; mem_rdata is taken in that same cycle.
//   out_valid/out_ready : an instruction transfers on a rising edge where both
//                     are high; outputs stay stable while out_valid is high and
//                     out_ready is low. out_valid is forced low while redirect=1.
module fetch_sequencer #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [7:0]        out_opcode,
    output logic [7:0]        out_b1,
    output logic [7:0]        out_b2,
    output logic [1:0]        out_instr_t,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        FETCH_OP = 3'd0,
        FETCH_B1 = 3'd1,
        FETCH_B2 = 3'd2,
        ISSUE    = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    // Instruction classes: 0 Normal, 1 NormalImm, 2 ExtOp, 3 ExtOpImm.
    function automatic logic [1:0] classify(input logic [7:0] op);
        logic [1:0] cls;
        cls = 2'd0;
        if (op[7:4] <= 4'h8) begin
            cls = 2'd0;
        end else if (op[7:4] <= 4'hB) begin
            cls = 2'd1;
        end else begin
            case (op[5:2])
                4'h2, 4'h3, 4'h7, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: cls = 2'd3;
                default:                                          cls = 2'd2;
            endcase
        end
        return cls;
    endfunction

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] drain_addr;
    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        opcode_q, b1_q, b2_q;
    logic [1:0]        type_q;
    logic [1:0]        op_cls;
    logic              latch_op, latch_b1, latch_b2, clear_bytes, enter_drain;

    assign op_cls = classify(mem_rdata);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH_OP;
        else     state <= state_d;
    end

    // Next-state and datapath strobes; a redirect overrides normal progress.
    always_comb begin
        state_d     = state;
        latch_op    = 1'b0;
        latch_b1    = 1'b0;
        latch_b2    = 1'b0;
        clear_bytes = 1'b0;
        enter_drain = 1'b0;
        case (state)
            FETCH_OP: if (mem_ack) begin
                latch_op = 1'b1;
                state_d  = (op_cls == 2'd0) ? ISSUE : FETCH_B1;
            end
            FETCH_B1: if (mem_ack) begin
                latch_b1 = 1'b1;
                state_d  = (type_q == 2'd3) ? FETCH_B2 : ISSUE;
            end
            FETCH_B2: if (mem_ack) begin
                latch_b2 = 1'b1;
                state_d  = ISSUE;
            end
            ISSUE: if (out_ready) begin
                clear_bytes = 1'b1;
                state_d     = FETCH_OP;
            end
            DRAIN: if (mem_ack) state_d = FETCH_OP;
            default: state_d = FETCH_OP;
        endcase
        if (redirect) begin
            latch_op    = 1'b0;
            latch_b1    = 1'b0;
            latch_b2    = 1'b0;
            clear_bytes = 1'b1;
            case (state)
                ISSUE:   state_d = FETCH_OP;
                DRAIN:   state_d = mem_ack ? FETCH_OP : DRAIN;
                default: begin
                    // An unanswered request is never abandoned: wait it out.
                    state_d     = mem_ack ? FETCH_OP : DRAIN;
                    enter_drain = !mem_ack;
                end
            endcase
        end
    end

    // PC, drain address and assembled instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            pc_q       <= RESET_PC;
            opcode_q   <= 8'h00;
            b1_q       <= 8'h00;
            b2_q       <= 8'h00;
            type_q     <= 2'd0;
        end else begin
            if (redirect)
                pc <= redirect_pc;
            else if (latch_op || latch_b1 || latch_b2)
                pc <= pc + ADDR_W'(1);
            if (enter_drain) drain_addr <= pc;
            if (latch_op) begin
                pc_q     <= pc;
                opcode_q <= mem_rdata;
                type_q   <= op_cls;
            end
            if (latch_b1) b1_q <= mem_rdata;
            if (latch_b2) b2_q <= mem_rdata;
            if (clear_bytes) begin
                b1_q <= 8'h00;
                b2_q <= 8'h00;
            end
        end
    end

    // Drain keeps presenting the address of the request still in flight.
    assign mem_req     = (state != ISSUE);
    assign mem_addr    = (state == DRAIN) ? drain_addr : pc;
    assign out_valid   = (state == ISSUE) && !redirect;
    assign out_pc      = pc_q;
    assign out_opcode  = opcode_q;
    assign out_b1      = b1_q;
    assign out_b2      = b2_q;
    assign out_instr_t = type_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run, with a
// transaction-level reference model predicting each issued instruction from
// the memory image and the architectural fetch PC.
module tb_fetch_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        mem_req, mem_ack = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] out_pc;
  logic [7:0]  out_opcode, out_b1, out_b2;
  logic [1:0]  out_instr_t;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [2:0]  dbg_state;

  // Second instance with a reset PC next to the address wrap.
  logic        rst2 = 1'b1;
  logic        mem_req2, mem_ack2;
  logic [15:0] mem_addr2;
  logic [7:0]  mem_rdata2;
  logic        out_valid2, out_ready2 = 1'b0;
  logic [15:0] out_pc2;
  logic [7:0]  out_opcode2, out_b1_2, out_b2_2;
  logic [1:0]  out_instr_t2;
  logic [2:0]  dbg_state2;

  logic [7:0] mem [0:65535];

  assign mem_ack2   = mem_req2;
  assign mem_rdata2 = mem[mem_addr2];

  fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_b1(out_b1), .out_b2(out_b2), .out_instr_t(out_instr_t),
    .redirect(redirect), .redirect_pc(redirect_pc), .dbg_state(dbg_state)
  );

  fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'hFFFE)) u_dut_wrap (
    .clk(clk), .rst(rst2), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(mem_ack2), .mem_rdata(mem_rdata2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_pc(out_pc2), .out_opcode(out_opcode2),
    .out_b1(out_b1_2), .out_b2(out_b2_2), .out_instr_t(out_instr_t2),
    .redirect(1'b0), .redirect_pc(16'h0000), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [41:0] exp_q[$];
  logic [15:0] model_pc = 16'h0000;
  logic        in_req = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  int          mem_wait = 0;
  int          lat_min = 0, lat_max = 0;
  int          cyc = 0, last_xfer_cyc = 0, xfer_count = 0;
  logic        gap_check = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_class(input logic [7:0] op);
    logic [15:0] imm_sel;
    int hi, sel;
    imm_sel = 16'h7C8C;            // selectors 2,3,7,A,B,C,D,E carry an immediate
    hi  = int'(op[7:4]);
    sel = int'(op[5:2]);
    if (hi < 9)  return 2'd0;
    if (hi < 12) return 2'd1;
    return imm_sel[sel] ? 2'd3 : 2'd2;
  endfunction

  function automatic int ref_len(input logic [1:0] cls);
    int lens[4];
    lens = '{1, 2, 2, 3};
    return lens[cls];
  endfunction

  // {pc, opcode, b1, b2, class} of the instruction starting at pc.
  function automatic logic [41:0] ref_instr(input logic [15:0] pc);
    logic [7:0]  op, b1, b2;
    logic [1:0]  cls;
    logic [15:0] p1, p2;
    p1  = pc + 16'd1;
    p2  = pc + 16'd2;
    op  = mem[pc];
    cls = ref_class(op);
    b1  = (ref_len(cls) > 1) ? mem[p1] : 8'h00;
    b2  = (ref_len(cls) > 2) ? mem[p2] : 8'h00;
    return {pc, op, b1, b2, cls};
  endfunction

  // ---------------- driver ----------------
  // One cycle: drive inputs and answer memory at the falling edge, then
  // observe just after and update the model for the coming rising edge.
  task automatic drive(input logic rdy, input logic redir, input logic [15:0] rpc, input logic r);
    logic [41:0] obs, exp;
    @(negedge clk);
    cyc++;
    rst         = r;
    out_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    mem_ack     = 1'b0;
    mem_rdata   = 8'($urandom);
    if (r) begin
      in_req = 1'b0;
    end else if (mem_req) begin
      if (!in_req) begin
        in_req   = 1'b1;
        req_addr = mem_addr;
        mem_wait = $urandom_range(lat_max, lat_min);
      end else begin
        check("mem_addr_stable", mem_addr, req_addr);
      end
      if (mem_wait == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        in_req    = 1'b0;
      end else begin
        mem_wait--;
      end
    end else if (in_req) begin
      check("mem_req_held", mem_req, 1);
      in_req = 1'b0;
    end
    #1;
    if (r) begin
      model_pc = 16'h0000;
    end else if (redir) begin
      check("valid_gated", out_valid, 0);
      model_pc = rpc;
    end else if (out_valid) begin
      check("req_low_in_issue", mem_req, 0);
      if (rdy) begin
        obs = {out_pc, out_opcode, out_b1, out_b2, out_instr_t};
        exp = ref_instr(model_pc);
        check("issue", obs, exp);
        if (exp_q.size() > 0) check("plan_issue", obs, exp_q.pop_front());
        if (gap_check && xfer_count > 0)
          check("issue_gap", cyc - last_xfer_cyc, ref_len(exp[1:0]) + 1);
        last_xfer_cyc = cyc;
        xfer_count++;
        model_pc = model_pc + 16'(ref_len(exp[1:0]));
      end
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    xfer_count = 0;
    exp_q.delete();
  endtask

  // ---------------- directed and random steps ----------------
  initial begin
    logic [7:0] img[12];
    img = '{8'h12, 8'h95, 8'h7F, 8'hC0, 8'h34, 8'hC8, 8'hAA, 8'hBB,
            8'h00, 8'h10, 8'h20, 8'h80};
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Wrap-around instance: C8 at FFFE straddles into 0000.
    mem[16'hFFFE] = 8'hC8;
    mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    out_ready2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (out_valid2) break;
    end
    check("wrap_reach_issue", out_valid2, 1);
    check("wrap_issue", {out_pc2, out_opcode2, out_b1_2, out_b2_2, out_instr_t2},
          {16'hFFFE, 8'hC8, 8'h11, 8'h22, 2'd3});
    @(negedge clk); #1;
    check("wrap_next_addr", mem_addr2, 16'h0001);
    check("wrap_next_req", mem_req2, 1);
    rst2 = 1'b1;

    // Reset values.
    for (int i = 0; i < 12; i++) mem[i] = img[i];
    mem[16'h0040] = 8'h30;
    mem[16'h0080] = 8'h05;
    lat_min = 0; lat_max = 0;
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 16'h0000);
    check("rst_out_bytes", {out_opcode, out_b1, out_b2, out_instr_t}, 0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_req", mem_req, 1);

    // Test-plan image, single-cycle ack, always ready.
    do_reset();
    gap_check = 1'b1;
    exp_q.push_back({16'h0000, 8'h12, 8'h00, 8'h00, 2'd0});
    exp_q.push_back({16'h0001, 8'h95, 8'h7F, 8'h00, 2'd1});
    exp_q.push_back({16'h0003, 8'hC0, 8'h34, 8'h00, 2'd2});
    exp_q.push_back({16'h0005, 8'hC8, 8'hAA, 8'hBB, 2'd3});
    for (int i = 0; i < 60 && xfer_count < 8; i++) drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check("plan_count", xfer_count, 8);
    check("plan_queue_empty", exp_q.size(), 0);
    gap_check = 1'b0;

    // Backpressure at the first issue.
    do_reset();
    for (int i = 0; i < 10 && !out_valid; i++) drive(1'b0, 1'b0, 16'h0000, 1'b0);
    check("bp_reach_issue", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'b0);
      check("bp_hold", {out_valid, out_pc, out_opcode, out_b1, out_b2, out_instr_t},
            {1'b1, 16'h0000, 8'h12, 8'h00, 8'h00, 2'd0});
      check("bp_req_low", mem_req, 0);
    end
    exp_q.push_back({16'h0000, 8'h12, 8'h00, 8'h00, 2'd0});
    exp_q.push_back({16'h0001, 8'h95, 8'h7F, 8'h00, 2'd1});
    for (int i = 0; i < 20 && xfer_count < 2; i++) drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check("bp_count", xfer_count, 2);

    // Redirect during the second-byte fetch of 0x95, slow memory.
    lat_min = 3; lat_max = 3;
    do_reset();
    exp_q.push_back({16'h0000, 8'h12, 8'h00, 8'h00, 2'd0});
    exp_q.push_back({16'h0040, 8'h30, 8'h00, 8'h00, 2'd0});
    for (int i = 0; i < 40 && !(in_req && req_addr == 16'h0002); i++)
      drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check("redir_reach_b1", {in_req, req_addr}, {1'b1, 16'h0002});
    drive(1'b1, 1'b1, 16'h0040, 1'b0);
    for (int i = 0; i < 10 && in_req; i++) begin
      check("drain_addr", {mem_req, mem_addr}, {1'b1, 16'h0002});
      drive(1'b1, 1'b0, 16'h0000, 1'b0);
    end
    check("drain_done", in_req, 0);
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check("redir_next_addr", {mem_req, mem_addr}, {1'b1, 16'h0040});
    for (int i = 0; i < 30 && xfer_count < 2; i++) drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check("redir_count", xfer_count, 2);

    // Redirect in the same cycle as a would-be transfer.
    lat_min = 0; lat_max = 0;
    do_reset();
    for (int i = 0; i < 10 && !out_valid; i++) drive(1'b0, 1'b0, 16'h0000, 1'b0);
    drive(1'b1, 1'b1, 16'h0080, 1'b0);
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check("issue_redir_addr", {mem_req, mem_addr}, {1'b1, 16'h0080});
    exp_q.push_back({16'h0080, 8'h05, 8'h00, 8'h00, 2'd0});
    for (int i = 0; i < 10 && xfer_count < 1; i++) drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check("issue_redir_count", xfer_count, 1);

    // Randomized traffic: latency, backpressure, redirects (some near the wrap).
    lat_min = 0; lat_max = 3;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        rdy, redir;
      logic [15:0] rpc;
      rdy   = ($urandom_range(9, 0) < 7);
      redir = ($urandom_range(39, 0) == 0);
      rpc   = ($urandom_range(3, 0) == 0) ? 16'hFFFC + 16'($urandom_range(3, 0))
                                          : 16'($urandom);
      drive(rdy, redir, rpc, 1'b0);
    end
    check("random_progress", (xfer_count > 100), 1);

    // Reset while fetching the third byte of C8 AA BB.
    mem[0] = 8'hC8; mem[1] = 8'hAA; mem[2] = 8'hBB;
    lat_min = 2; lat_max = 2;
    do_reset();
    for (int i = 0; i < 30 && !(in_req && req_addr == 16'h0002); i++)
      drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check("rst_reach_b2", {in_req, req_addr}, {1'b1, 16'h0002});
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check("midrst_valid", out_valid, 0);
    check("midrst_addr", {mem_req, mem_addr}, {1'b1, 16'h0000});
    check("midrst_state", dbg_state, 3'd0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
